// File: rtl/gato_pkg.sv
// Shared definitions for the tic-tac-toe board controller: cell codes,
// controller states and the table of the eight winning lines.
package gato_pkg;

    localparam logic [1:0] VACIA  = 2'b00;
    localparam logic [1:0] JUG_X  = 2'b01;
    localparam logic [1:0] JUG_O  = 2'b10;
    localparam logic [1:0] EMPATE = 2'b11;

    localparam int NUM_CELDAS = 9;
    localparam int NUM_LINEAS = 8;

    typedef enum logic [2:0] {
        INICIO  = 3'd0,
        ESPERA  = 3'd1,
        VALIDA  = 3'd2,
        ESCRIBE = 3'd3,
        EVALUA  = 3'd4,
        FIN     = 3'd5
    } estado_t;

    // Cell index is 3*y + x: three rows, three columns, two diagonals.
    localparam int LINEAS [NUM_LINEAS][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic logic [1:0] otro_jugador(input logic [1:0] jugador);
        return (jugador == JUG_X) ? JUG_O : JUG_X;
    endfunction

endpackage

// File: rtl/gato_detector_linea.sv
// Combinational three-in-a-row detector: gana is high when jugador owns
// every cell of at least one of the eight lines.
module gato_detector_linea
    import gato_pkg::*;
(
    input  logic [17:0] tablero,
    input  logic [1:0]  jugador,
    output logic        gana
);

    logic [NUM_LINEAS-1:0] linea_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINEAS; gi++) begin : g_linea
            assign linea_hit[gi] = (tablero[2*LINEAS[gi][0] +: 2] == jugador) &&
                                   (tablero[2*LINEAS[gi][1] +: 2] == jugador) &&
                                   (tablero[2*LINEAS[gi][2] +: 2] == jugador);
        end
    endgenerate

    assign gana = |linea_hit;

endmodule

// File: rtl/gato_tablero_ctrl.sv
// Tic-tac-toe board owner: edge-detects enter, validates and commits moves,
// alternates turns and reports win/draw.
// Optional feature macro GATO_PUNTAJE_EN adds saturating per-player win
// counters (puntajeX/puntajeO) that only reset_n clears.
module gato_tablero_ctrl
    import gato_pkg::*;
#(
    parameter int JUGADOR_INICIAL = 1
`ifdef GATO_PUNTAJE_EN
    ,
    // Only meaningful when the score counters are built.
    parameter int PUNTAJE_W = 4
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  posX,
    input  logic [2:0]  posY,
    input  logic        enter,
    input  logic        reiniciar,
    output logic [17:0] tablero,
    output logic [1:0]  turno,
    output logic [1:0]  ganador,
    output logic        finJuego,
    output logic        jugadaInvalida,
    output logic        ocupado
`ifdef GATO_PUNTAJE_EN
    ,
    output logic [PUNTAJE_W-1:0] puntajeX,
    output logic [PUNTAJE_W-1:0] puntajeO
`endif
);

    localparam logic [1:0] TURNO_INICIAL = (JUGADOR_INICIAL == 2) ? JUG_O : JUG_X;

    estado_t     state_reg, state_next;
    logic        enter_q;
    logic        flanco;
    logic [2:0]  x_reg, y_reg;
    logic [17:0] tablero_reg, tablero_next;
    logic [1:0]  turno_reg;
    logic [1:0]  ganador_reg;
    logic [3:0]  movimientos_reg;
    logic        invalida_reg;
    logic        coords_ok;
    logic [3:0]  idx;
    logic        celda_libre;
    logic        jugada_ok;
    logic        gana;
    logic [NUM_CELDAS-1:0] wr_sel;
    logic [1:0]  celdas [NUM_CELDAS];

    assign flanco    = enter & ~enter_q;
    assign coords_ok = (x_reg <= 3'd2) && (y_reg <= 3'd2);
    // Out-of-range coordinates fold to cell 0 so the board lookup stays in bounds.
    assign idx       = coords_ok ? (4'(y_reg) * 4'd3 + 4'(x_reg)) : 4'd0;
    assign celda_libre = (celdas[idx] == VACIA);
    assign jugada_ok = coords_ok && celda_libre;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CELDAS; gi++) begin : g_celda
            assign celdas[gi] = tablero_reg[2*gi +: 2];
            assign wr_sel[gi] = (idx == 4'(gi));
        end
    endgenerate

    gato_detector_linea u_detector (
        .tablero (tablero_reg),
        .jugador (turno_reg),
        .gana    (gana)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= INICIO;
        else          state_reg <= state_next;
    end

    // Next-state logic; a restart overrides whatever step is in progress.
    always_comb begin
        state_next = state_reg;
        if (reiniciar) begin
            state_next = INICIO;
        end else begin
            case (state_reg)
                INICIO:  state_next = ESPERA;
                ESPERA:  if (flanco) state_next = VALIDA;
                VALIDA:  state_next = jugada_ok ? ESCRIBE : ESPERA;
                ESCRIBE: state_next = EVALUA;
                EVALUA:  state_next = (gana || movimientos_reg == 4'd9) ? FIN : ESPERA;
                FIN:     state_next = FIN;
                default: state_next = INICIO;
            endcase
        end
    end

    // Board update: cleared on INICIO, one cell written in ESCRIBE unless aborted.
    always_comb begin
        tablero_next = tablero_reg;
        if (state_reg == INICIO) begin
            tablero_next = '0;
        end else if (state_reg == ESCRIBE && !reiniciar) begin
            for (int i = 0; i < NUM_CELDAS; i++) begin
                if (wr_sel[i]) tablero_next[2*i +: 2] = turno_reg;
            end
        end
    end

    // Game datapath: edge history, latched coordinates, turn, move count, result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enter_q         <= 1'b0;
            x_reg           <= 3'd0;
            y_reg           <= 3'd0;
            tablero_reg     <= '0;
            turno_reg       <= TURNO_INICIAL;
            ganador_reg     <= VACIA;
            movimientos_reg <= 4'd0;
            invalida_reg    <= 1'b0;
        end else begin
            enter_q      <= enter;
            tablero_reg  <= tablero_next;
            invalida_reg <= (state_reg == VALIDA) && !reiniciar && !jugada_ok;
            case (state_reg)
                INICIO: begin
                    ganador_reg     <= VACIA;
                    movimientos_reg <= 4'd0;
                    turno_reg       <= TURNO_INICIAL;
                end
                ESPERA: begin
                    if (flanco && !reiniciar) begin
                        x_reg <= posX;
                        y_reg <= posY;
                    end
                end
                ESCRIBE: begin
                    if (!reiniciar) movimientos_reg <= movimientos_reg + 4'd1;
                end
                EVALUA: begin
                    if (!reiniciar) begin
                        if (gana)                         ganador_reg <= turno_reg;
                        else if (movimientos_reg == 4'd9) ganador_reg <= EMPATE;
                        else                              turno_reg   <= otro_jugador(turno_reg);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GATO_PUNTAJE_EN
    // Win counters: bumped on the EVALUA->FIN step of a win, saturating, immune to reiniciar.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            puntajeX <= '0;
            puntajeO <= '0;
        end else if (state_reg == EVALUA && !reiniciar && gana) begin
            if (turno_reg == JUG_X && puntajeX != '1) puntajeX <= puntajeX + 1'b1;
            if (turno_reg == JUG_O && puntajeO != '1) puntajeO <= puntajeO + 1'b1;
        end
    end
`endif

    assign tablero        = tablero_reg;
    assign turno          = turno_reg;
    assign ganador        = ganador_reg;
    assign finJuego       = (state_reg == FIN);
    assign jugadaInvalida = invalida_reg;
    assign ocupado        = (state_reg != ESPERA);

endmodule

// File: tb/tb_gato_tablero_ctrl.sv
// Self-checking bench for gato_tablero_ctrl: scripted games from a vector
// table, restart corner cases, then random games against a board model.
// Build with GATO_PUNTAJE_EN defined to also check the score counters.
module tb_gato_tablero_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  posX, posY;
    logic        enter, reiniciar;
    logic [17:0] tablero;
    logic [1:0]  turno, ganador;
    logic        finJuego, jugadaInvalida, ocupado;
`ifdef GATO_PUNTAJE_EN
    logic [3:0]  puntajeX, puntajeO;
`endif

    gato_tablero_ctrl #(.JUGADOR_INICIAL(1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .posX           (posX),
        .posY           (posY),
        .enter          (enter),
        .reiniciar      (reiniciar),
        .tablero        (tablero),
        .turno          (turno),
        .ganador        (ganador),
        .finJuego       (finJuego),
        .jugadaInvalida (jugadaInvalida),
        .ocupado        (ocupado)
`ifdef GATO_PUNTAJE_EN
        ,
        .puntajeX       (puntajeX),
        .puntajeO       (puntajeO)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference game state: cells 0 empty / 1 X / 2 O, index 3*y+x.
    int m_b [9];
    int m_turn;
    int m_moves;
    int m_gan;
    bit m_fin;
    logic inval_seen;

    typedef struct {
        int         x;
        int         y;
        bit         hold;
        bit         rst;
        bit         inval;
        logic [1:0] turno;
        logic [1:0] gan;
        bit         fin;
    } vec_t;

    vec_t tabla[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void modelo_reset();
        for (int i = 0; i < 9; i++) m_b[i] = 0;
        m_turn  = 1;
        m_moves = 0;
        m_gan   = 0;
        m_fin   = 1'b0;
    endfunction

    function automatic logic [17:0] modelo_tablero();
        logic [17:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[2*i +: 2] = 2'(m_b[i]);
        return r;
    endfunction

    function automatic bit modelo_gana(input int p);
        for (int r = 0; r < 3; r++)
            if (m_b[3*r] == p && m_b[3*r+1] == p && m_b[3*r+2] == p) return 1'b1;
        for (int c = 0; c < 3; c++)
            if (m_b[c] == p && m_b[c+3] == p && m_b[c+6] == p) return 1'b1;
        if (m_b[0] == p && m_b[4] == p && m_b[8] == p) return 1'b1;
        if (m_b[2] == p && m_b[4] == p && m_b[6] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic vec_t mv(input int x, input int y, input bit hold, input bit inval,
                                input logic [1:0] t, input logic [1:0] g, input bit f);
        vec_t v;
        v.x = x; v.y = y; v.hold = hold; v.rst = 1'b0; v.inval = inval;
        v.turno = t; v.gan = g; v.fin = f;
        return v;
    endfunction

    function automatic vec_t rst_row();
        vec_t v;
        v = mv(0, 0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);
        v.rst = 1'b1;
        return v;
    endfunction

    // One enter edge at (x,y); outputs are sampled on falling edges.
    task automatic jugar(input int x, input int y, input bit hold);
        bit ok;
        int idx;
        logic [17:0] antes;
        antes = tablero;
        ok  = !m_fin && x < 3 && y < 3 && m_b[3*y+x] == 0;
        idx = 3*y + x;
        posX = 3'(x); posY = 3'(y); enter = 1'b1;
        @(negedge clk);
        check("ocupado_tras_flanco", ocupado, 1);
        if (!hold) enter = 1'b0;
        // Coordinates were latched on the edge; scrambling them must not matter.
        posX = 3'($urandom); posY = 3'($urandom);
        @(negedge clk);
        inval_seen = jugadaInvalida;
        check("jugadaInvalida", jugadaInvalida, (!ok && !m_fin) ? 1 : 0);
        check("tablero_aun_sin_cambio", tablero, antes);
        @(negedge clk);
        check("pulso_invalida_un_ciclo", jugadaInvalida, 0);
        if (ok) begin
            m_b[idx] = m_turn;
            m_moves++;
        end
        check("tablero", tablero, modelo_tablero());
        if (ok) begin
            check("ganador_antes_de_evaluar", ganador, m_gan);
            @(negedge clk);
            if (modelo_gana(m_turn)) begin
                m_gan = m_turn; m_fin = 1'b1;
            end else if (m_moves == 9) begin
                m_gan = 3; m_fin = 1'b1;
            end else begin
                m_turn = 3 - m_turn;
            end
        end
        check("ganador", ganador, m_gan);
        check("finJuego", finJuego, m_fin);
        check("turno", turno, m_turn);
        check("ocupado", ocupado, m_fin);
        if (hold) begin
            repeat (3) @(negedge clk);
            check("sin_autorepeticion_tablero", tablero, modelo_tablero());
            check("sin_autorepeticion_ocupado", ocupado, m_fin);
            enter = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic reinicio();
        reiniciar = 1'b1;
        enter = 1'b0;
        @(negedge clk);
        reiniciar = 1'b0;
        @(negedge clk);
        modelo_reset();
        check("reinicio_tablero", tablero, 0);
        check("reinicio_turno", turno, 1);
        check("reinicio_ganador", ganador, 0);
        check("reinicio_fin", finJuego, 0);
        check("reinicio_ocupado", ocupado, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Game A: first move, occupied cell, out-of-range column.
        tabla.push_back(mv(1, 1, 0, 0, 2'd2, 2'd0, 0));
        tabla.push_back(mv(1, 1, 0, 1, 2'd2, 2'd0, 0));
        tabla.push_back(mv(3, 0, 0, 1, 2'd2, 2'd0, 0));
        tabla.push_back(rst_row());
        // Game B: X wins on the top row at move 5, then an ignored edge.
        tabla.push_back(mv(0, 0, 0, 0, 2'd2, 2'd0, 0));
        tabla.push_back(mv(0, 1, 0, 0, 2'd1, 2'd0, 0));
        tabla.push_back(mv(1, 0, 0, 0, 2'd2, 2'd0, 0));
        tabla.push_back(mv(1, 1, 0, 0, 2'd1, 2'd0, 0));
        tabla.push_back(mv(2, 0, 0, 0, 2'd1, 2'd1, 1));
        tabla.push_back(mv(2, 2, 0, 0, 2'd1, 2'd1, 1));
        tabla.push_back(rst_row());
        // Game C: full board, no line -> draw.
        tabla.push_back(mv(0, 0, 0, 0, 2'd2, 2'd0, 0));
        tabla.push_back(mv(1, 0, 0, 0, 2'd1, 2'd0, 0));
        tabla.push_back(mv(2, 0, 0, 0, 2'd2, 2'd0, 0));
        tabla.push_back(mv(1, 1, 0, 0, 2'd1, 2'd0, 0));
        tabla.push_back(mv(0, 1, 0, 0, 2'd2, 2'd0, 0));
        tabla.push_back(mv(0, 2, 0, 0, 2'd1, 2'd0, 0));
        tabla.push_back(mv(1, 2, 0, 0, 2'd2, 2'd0, 0));
        tabla.push_back(mv(2, 1, 0, 0, 2'd1, 2'd0, 0));
        tabla.push_back(mv(2, 2, 0, 0, 2'd1, 2'd3, 1));
        tabla.push_back(rst_row());
        // Game D: X wins with the 9th move (diagonal); some moves hold enter.
        tabla.push_back(mv(0, 0, 0, 0, 2'd2, 2'd0, 0));
        tabla.push_back(mv(1, 0, 1, 0, 2'd1, 2'd0, 0));
        tabla.push_back(mv(2, 0, 0, 0, 2'd2, 2'd0, 0));
        tabla.push_back(mv(0, 1, 0, 0, 2'd1, 2'd0, 0));
        tabla.push_back(mv(1, 1, 1, 0, 2'd2, 2'd0, 0));
        tabla.push_back(mv(0, 2, 0, 0, 2'd1, 2'd0, 0));
        tabla.push_back(mv(1, 2, 0, 0, 2'd2, 2'd0, 0));
        tabla.push_back(mv(2, 1, 0, 0, 2'd1, 2'd0, 0));
        tabla.push_back(mv(2, 2, 0, 0, 2'd1, 2'd1, 1));

        // Reset state.
        reset_n = 1'b0; enter = 1'b0; reiniciar = 1'b0; posX = 3'd0; posY = 3'd0;
        modelo_reset();
        repeat (2) @(negedge clk);
        check("rst_tablero", tablero, 0);
        check("rst_turno", turno, 1);
        check("rst_ganador", ganador, 0);
        check("rst_fin", finJuego, 0);
        check("rst_invalida", jugadaInvalida, 0);
        check("rst_ocupado", ocupado, 1);
        reset_n = 1'b1;
        @(negedge clk);
        check("espera_ocupado", ocupado, 0);
        check("espera_tablero", tablero, 0);
        check("espera_turno", turno, 1);

        // Directed vectors.
        for (int i = 0; i < tabla.size(); i++) begin
            if (tabla[i].rst) begin
                reinicio();
            end else begin
                jugar(tabla[i].x, tabla[i].y, tabla[i].hold);
                check($sformatf("tabla%0d_invalida", i), inval_seen, tabla[i].inval);
                check($sformatf("tabla%0d_turno", i), turno, tabla[i].turno);
                check($sformatf("tabla%0d_ganador", i), ganador, tabla[i].gan);
                check($sformatf("tabla%0d_fin", i), finJuego, tabla[i].fin);
            end
        end
`ifdef GATO_PUNTAJE_EN
        check("puntajeX_tras_tabla", puntajeX, 2);
        check("puntajeO_tras_tabla", puntajeO, 0);
`endif

        // reiniciar together with an enter edge: restart wins, nothing written.
        posX = 3'd2; posY = 3'd2; enter = 1'b1; reiniciar = 1'b1;
        @(negedge clk);
        reiniciar = 1'b0; enter = 1'b0;
        @(negedge clk);
        repeat (4) @(negedge clk);
        modelo_reset();
        check("rst_con_flanco_tablero", tablero, 0);
        check("rst_con_flanco_turno", turno, 1);
        check("rst_con_flanco_ocupado", ocupado, 0);
        check("rst_con_flanco_ganador", ganador, 0);

        // reiniciar while in ESCRIBE: the in-flight move is discarded.
        jugar(0, 0, 1'b0);
        posX = 3'd2; posY = 3'd2; enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        reiniciar = 1'b1;
        @(negedge clk);
        check("abort_escribe_sin_escritura", tablero, modelo_tablero());
        reiniciar = 1'b0;
        @(negedge clk);
        modelo_reset();
        check("abort_escribe_tablero", tablero, 0);
        check("abort_escribe_turno", turno, 1);
        check("abort_escribe_ocupado", ocupado, 0);
`ifdef GATO_PUNTAJE_EN
        check("puntajeX_tras_reiniciar", puntajeX, 2);
`endif

        // Random games against the model.
        for (int g = 0; g < 8; g++) begin
            reinicio();
            for (int k = 0; k < 30 && !m_fin; k++) begin
                jugar(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 4) == 0));
            end
            if (m_fin) jugar(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
